// File: rtl/inst_pkg.sv
// Shared instruction-field definitions for the loader (packing) and the splitter (unpacking).
package inst_pkg;

    // Instruction format selector
    localparam logic [1:0] FMT_R   = 2'd0;
    localparam logic [1:0] FMT_I   = 2'd1;
    localparam logic [1:0] FMT_J   = 2'd2;
    localparam logic [1:0] FMT_BAD = 2'd3;

    // Field bit positions inside a 32-bit MIPS word
    localparam int OP_HI    = 31;
    localparam int OP_LO    = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int SH_HI    = 10;
    localparam int SH_LO    = 6;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;
    localparam int JADDR_HI = 25;
    localparam int JADDR_LO = 0;

    // One field tuple as presented on the input handshake
    typedef struct packed {
        logic [1:0]  fmt;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm16;
        logic [25:0] jaddr;
    } inst_fields_t;

    // Loader FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } ld_state_t;

endpackage

// File: rtl/inst_field_packer.sv
// Combinational field-tuple to 32-bit instruction word. Illegal format packs a NOP and flags it.
module inst_field_packer
    import inst_pkg::*;
(
    input  inst_fields_t f,
    output logic [31:0]  word,
    output logic         illegal
);

    // Place fields by format; fields not used by the selected format are dropped
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (f.fmt)
            FMT_R: begin
                word[OP_HI:OP_LO]       = f.op;
                word[RS_HI:RS_LO]       = f.rs;
                word[RT_HI:RT_LO]       = f.rt;
                word[RD_HI:RD_LO]       = f.rd;
                word[SH_HI:SH_LO]       = f.shamt;
                word[FUNCT_HI:FUNCT_LO] = f.funct;
            end
            FMT_I: begin
                word[OP_HI:OP_LO]   = f.op;
                word[RS_HI:RS_LO]   = f.rs;
                word[RT_HI:RT_LO]   = f.rt;
                word[IMM_HI:IMM_LO] = f.imm16;
            end
            FMT_J: begin
                word[OP_HI:OP_LO]       = f.op;
                word[JADDR_HI:JADDR_LO] = f.jaddr;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/inst_packer_loader.sv
// Boot/test loader: takes field tuples over valid/ready, packs them into MIPS words and
// writes them to consecutive IM addresses, one word every two cycles, framed by start/count.
module inst_packer_loader
    import inst_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [5:0]        op,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm16,
    input  logic [25:0]       jaddr,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              wrap,
    output logic [31:0]       checksum
);

    ld_state_t         state;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  remaining;
    inst_fields_t      fields;
    logic [31:0]       pk_word;
    logic              pk_illegal;

    assign fields = '{fmt: fmt, op: op, rs: rs, rt: rt, rd: rd, shamt: shamt,
                      funct: funct, imm16: imm16, jaddr: jaddr};

    inst_field_packer u_packer (
        .f       (fields),
        .word    (pk_word),
        .illegal (pk_illegal)
    );

    // Run FSM; all outputs are registered. im_wdata doubles as the word register so the
    // WRITE cycle presents exactly the word captured at the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr      <= '0;
            remaining <= '0;
            in_ready  <= 1'b0;
            im_we     <= 1'b0;
            im_addr   <= '0;
            im_wdata  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            wrap      <= 1'b0;
            checksum  <= '0;
        end else begin
            im_we <= 1'b0;
            done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        addr      <= base_addr;
                        remaining <= count;
                        err       <= 1'b0;
                        wrap      <= 1'b0;
                        checksum  <= '0;
                        busy      <= 1'b1;
                        if (count == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= ST_LOAD;
                            in_ready <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (in_valid && in_ready) begin
                        im_we    <= 1'b1;
                        im_addr  <= addr;
                        im_wdata <= pk_word;
                        err      <= err | pk_illegal;
                        in_ready <= 1'b0;
                        state    <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    checksum  <= checksum ^ im_wdata;
                    remaining <= remaining - CNT_W'(1);
                    addr      <= addr + ADDR_W'(1);
                    if (&addr) wrap <= 1'b1;
                    if (remaining == CNT_W'(1)) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= ST_LOAD;
                        in_ready <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
